// File: rtl/clock_div_bank_if.sv
// Configuration write port for clock_div_bank: valid/ready divisor writes plus a bad-index error pulse.
// Master drives the request fields; slave returns ready and the registered error strobe.
interface clock_div_bank_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers, each giving a 1-cycle tick and a 50% square wave.
// All outputs registered; cfg_ready is high whenever out of reset, so one write is taken per cycle.
module clock_div_bank #(
    parameter int                        NUM_CH   = 4,
    parameter int                        CNT_W    = 32,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {32'd33333333, 32'd500000,
                                                     32'd25000000, 32'd50000000}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sync,
    clock_div_bank_if.slave   cfg,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic              cfg_ready_q;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_acc;

    assign cfg_acc = cfg.cfg_valid & cfg_ready_q;

    always_comb begin
        cfg_err_d = cfg_acc && ({1'b0, cfg.cfg_ch} >= NUM_CH_W);
        tick_d    = '0;
        sq_d      = sq_q;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
            // Restarts (write, then sync) outrank the wrap, so a restart in the wrap cycle drops that tick.
            if (cfg_acc && (cfg.cfg_ch == 4'(i))) begin
                div_d[i] = cfg.cfg_div;
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (sync) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (!run || (div_q[i] == '0)) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                sq_d[i]   = ~sq_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
                cnt_q[i] <= '0;
            end
            tick_q      <= '0;
            sq_q        <= '0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            tick_q      <= tick_d;
            sq_q        <= sq_d;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign tick          = tick_q;
    assign sq            = sq_q;
    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed bench for clock_div_bank: 4 channels with divisors ch0=5, ch1=3, ch2=4, ch3=7.
// Outputs sampled on the falling edge; each expected value below is worked out by hand per cycle.
module tb_clock_div_bank;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    clock_div_bank_if #(.CNT_W(CW)) cfg_if ();

    clock_div_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV_INIT ({8'd7, 8'd4, 8'd3, 8'd5})
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .sync (sync),
        .cfg  (cfg_if.slave),
        .tick (tick),
        .sq   (sq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle write; on return the outputs reflect the accepting edge.
    task automatic cfg_wr(input logic [3:0] ch, input logic [CW-1:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_div   = d;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    logic [3:0] t1_tick [15] = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h1, 4'h2, 4'h8, 4'h4,
                                 4'h2, 4'h1, 4'h0, 4'h6, 4'h0, 4'h8, 4'h3};
    logic [3:0] t1_sq   [15] = '{4'h0, 4'h0, 4'h2, 4'h6, 4'h7, 4'h5, 4'hd, 4'h9,
                                 4'hb, 4'ha, 4'ha, 4'hc, 4'hc, 4'h4, 4'h7};
    logic [3:0] t2_tick [4]  = '{4'h0, 4'h0, 4'h2, 4'h4};
    logic [3:0] t3_tick [4]  = '{4'h4, 4'h3, 4'h0, 4'h1};
    logic       t3_sq0  [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] t4_tick [6]  = '{4'h6, 4'h1, 4'h8, 4'h3, 4'h4, 4'h1};
    logic [3:0] t5_tick [4]  = '{4'h0, 4'h1, 4'ha, 4'h5};
    logic [3:0] t6_tick [5]  = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        run              = 1'b0;
        sync             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        step();
        step();
        chk("rst_tick",  32'(tick), 32'h0);
        chk("rst_sq",    32'(sq), 32'h0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
        chk("rst_err",   32'(cfg_if.cfg_err), 32'h0);

        // T1: free running from reset release.
        rst = 1'b0;
        run = 1'b1;
        for (int n = 0; n < 15; n++) begin
            step();
            if (n == 0) chk("t1_ready", 32'(cfg_if.cfg_ready), 32'h1);
            chk($sformatf("t1_tick_c%0d", n + 1), 32'(tick), 32'(t1_tick[n]));
            chk($sformatf("t1_sq_c%0d", n + 1),   32'(sq),   32'(t1_sq[n]));
        end

        // T2: sync restart, then freeze 4 cycles mid-period.
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t2_sync_tick", 32'(tick), 32'h0);
        chk("t2_sync_sq",   32'(sq), 32'h0);
        for (int m = 0; m < 4; m++) begin
            step();
            chk($sformatf("t2_tick_m%0d", m + 1), 32'(tick), 32'(t2_tick[m]));
        end
        chk("t2_sq_m4", 32'(sq), 32'h6);
        run = 1'b0;
        for (int m = 0; m < 4; m++) begin
            step();
            chk($sformatf("t2_frz_tick%0d", m), 32'(tick), 32'h0);
            chk($sformatf("t2_frz_sq%0d", m),   32'(sq), 32'h6);
        end
        run = 1'b1;
        step();
        chk("t2_resume_m9",  32'(tick), 32'h1);
        step();
        chk("t2_resume_m10", 32'(tick), 32'h2);

        // T3: reprogram ch0 to 2.
        cfg_wr(4'd0, 8'd2);
        chk("t3_wr_tick", 32'(tick), 32'h8);
        chk("t3_wr_sq0",  32'(sq[0]), 32'h0);
        chk("t3_wr_err",  32'(cfg_if.cfg_err), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_tick_k%0d", k + 1), 32'(tick), 32'(t3_tick[k]));
            chk($sformatf("t3_sq0_k%0d", k + 1),  32'(sq[0]), 32'(t3_sq0[k]));
        end

        // T4: out-of-range channel is dropped with an error pulse.
        cfg_wr(4'd7, 8'd9);
        chk("t4_err_hi", 32'(cfg_if.cfg_err), 32'h1);
        chk("t4_tick_e0", 32'(tick), 32'(t4_tick[0]));
        step();
        chk("t4_err_lo", 32'(cfg_if.cfg_err), 32'h0);
        chk("t4_tick_e1", 32'(tick), 32'(t4_tick[1]));
        for (int e = 2; e < 6; e++) begin
            step();
            chk($sformatf("t4_tick_e%0d", e), 32'(tick), 32'(t4_tick[e]));
        end

        // T5: sync plus a write to ch3 landing on ch1's wrap edge.
        sync = 1'b1;
        cfg_wr(4'd3, 8'd3);
        sync = 1'b0;
        chk("t5_wrap_tick", 32'(tick), 32'h0);
        chk("t5_wrap_sq",   32'(sq), 32'h0);
        for (int r = 0; r < 4; r++) begin
            step();
            chk($sformatf("t5_tick_r%0d", r + 1), 32'(tick), 32'(t5_tick[r]));
        end

        // D==1 then D==0 on ch2.
        cfg_wr(4'd2, 8'd1);
        chk("d1_wr_tick", 32'(tick), 32'h0);
        step();
        chk("d1_tick_a", 32'(tick), 32'hf);
        chk("d1_sq2_a",  32'(sq[2]), 32'h1);
        step();
        chk("d1_tick_b", 32'(tick), 32'h4);
        chk("d1_sq2_b",  32'(sq[2]), 32'h0);
        cfg_wr(4'd2, 8'd0);
        chk("d0_wr_tick2", 32'(tick[2]), 32'h0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("d0_tick2_%0d", s), 32'(tick[2]), 32'h0);
            chk($sformatf("d0_sq2_%0d", s),   32'(sq[2]), 32'h0);
        end

        // T6: reset mid-count after a write restores DIV_INIT.
        cfg_wr(4'd0, 8'd9);
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_tick",  32'(tick), 32'h0);
        chk("t6_rst_sq",    32'(sq), 32'h0);
        chk("t6_rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (n == 0) chk("t6_ready", 32'(cfg_if.cfg_ready), 32'h1);
            chk($sformatf("t6_tick_c%0d", n + 1), 32'(tick), 32'(t6_tick[n]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
